// File: rtl/crossbar_slave_arbiter.sv
// Per-slave-port arbiter and sequencer for the 2-master/2-slave crossbar.
// Latency: grant registered one edge after a hit; ack/rdata routed combinationally.
// Backpressure: grant held until slave_ack or abort (optional watchdog: ARB_TIMEOUT_EN).
module crossbar_slave_arbiter #(
  parameter logic SLAVE_SEL      = 1'b0,
  parameter int   ADDR_W         = 32,
  parameter int   DATA_W         = 32,
  parameter int   TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              master_1_req,
  input  logic [ADDR_W-1:0] master_1_addr,
  input  logic [DATA_W-1:0] master_1_wdata,
  input  logic              master_1_cmd,
  input  logic              master_2_req,
  input  logic [ADDR_W-1:0] master_2_addr,
  input  logic [DATA_W-1:0] master_2_wdata,
  input  logic              master_2_cmd,
  output logic              master_1_ack,
  output logic              master_2_ack,
  output logic [DATA_W-1:0] master_1_rdata,
  output logic [DATA_W-1:0] master_2_rdata,
  output logic              slave_req,
  output logic [ADDR_W-1:0] slave_addr,
  output logic [DATA_W-1:0] slave_wdata,
  output logic              slave_cmd,
  input  logic              slave_ack,
  input  logic [DATA_W-1:0] slave_rdata,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  // State encoding matches the one-hot grant layout (bit0 = M1, bit1 = M2).
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GNT_M1 = 2'b01;
  localparam logic [1:0] ST_GNT_M2 = 2'b10;

  // Round-robin pointer: which master completed (or lost) the grant most recently.
  localparam logic LAST_M1 = 1'b0;
  localparam logic LAST_M2 = 1'b1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       last_nxt;
  logic       hit_1;
  logic       hit_2;
  logic       tout_limit;

  // A watchdog limit below 2 cannot be honoured; an illegal value shows up as
  // this named block in the elaborated hierarchy.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_invalid
  end

  assign hit_1 = master_1_req && (master_1_addr[ADDR_W-1] == SLAVE_SEL);
  assign hit_2 = master_2_req && (master_2_addr[ADDR_W-1] == SLAVE_SEL);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tout_cnt;
  logic             tout_fire;
  logic             tout_err_q;

  // The limit is hit on the last allowed GNT cycle, so the grant lasts exactly
  // TIMEOUT_CYCLES cycles before the FSM gives up.
  assign tout_limit = (tout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // A timeout only fires when neither ack nor abort takes precedence.
  assign tout_fire = tout_limit && !slave_ack &&
                     (((state == ST_GNT_M1) && master_1_req) ||
                      ((state == ST_GNT_M2) && master_2_req));

  // Count GNT cycles without ack; restart on every new grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tout_cnt <= '0;
    end else if ((state == ST_IDLE) || (state_nxt != state)) begin
      tout_cnt <= '0;
    end else begin
      tout_cnt <= tout_cnt + CNT_W'(1);
    end
  end

  // One-cycle error pulse in the cycle after the watchdog drops the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tout_err_q <= 1'b0;
    end else begin
      tout_err_q <= tout_fire;
    end
  end

  assign timeout_err = tout_err_q;
`else
  assign tout_limit  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state and round-robin pointer update.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (hit_1 && hit_2) begin
          state_nxt = (last == LAST_M1) ? ST_GNT_M2 : ST_GNT_M1;
        end else if (hit_1) begin
          state_nxt = ST_GNT_M1;
        end else if (hit_2) begin
          state_nxt = ST_GNT_M2;
        end
      end
      ST_GNT_M1: begin
        if (slave_ack) begin
          // Never re-grant the same master straight away.
          last_nxt  = LAST_M1;
          state_nxt = hit_2 ? ST_GNT_M2 : ST_IDLE;
        end else if (!master_1_req) begin
          last_nxt  = LAST_M1;
          state_nxt = ST_IDLE;
        end else if (tout_limit) begin
          last_nxt  = LAST_M1;
          state_nxt = ST_IDLE;
        end
      end
      ST_GNT_M2: begin
        if (slave_ack) begin
          last_nxt  = LAST_M2;
          state_nxt = hit_1 ? ST_GNT_M1 : ST_IDLE;
        end else if (!master_2_req) begin
          last_nxt  = LAST_M2;
          state_nxt = ST_IDLE;
        end else if (tout_limit) begin
          last_nxt  = LAST_M2;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM, pointer and grant registers; reset leaves M1 the winner of the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      last  <= LAST_M2;
      grant <= 2'b00;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      grant <= state_nxt;
    end
  end

  // Request path to the slave and response path back, selected by the current grant.
  always_comb begin
    slave_req      = 1'b0;
    slave_addr     = '0;
    slave_wdata    = '0;
    slave_cmd      = 1'b0;
    master_1_ack   = 1'b0;
    master_2_ack   = 1'b0;
    master_1_rdata = '0;
    master_2_rdata = '0;
    case (state)
      ST_GNT_M1: begin
        slave_req      = master_1_req;
        slave_addr     = master_1_addr;
        slave_wdata    = master_1_wdata;
        slave_cmd      = master_1_cmd;
        master_1_ack   = slave_ack;
        master_1_rdata = slave_rdata;
      end
      ST_GNT_M2: begin
        slave_req      = master_2_req;
        slave_addr     = master_2_addr;
        slave_wdata    = master_2_wdata;
        slave_cmd      = master_2_cmd;
        master_2_ack   = slave_ack;
        master_2_rdata = slave_rdata;
      end
      default: begin
      end
    endcase
  end

endmodule
